id_scanner: RTL
===============

ID_SCANNER -- requirements
Module: id_scanner

Interface
REQ-001 SHALL have parameter LEN_W, default 4, width of token-length field.
REQ-002 SHALL have parameter CNT_W, default 8, width of identifier counter.
REQ-003 SHALL have parameter ALLOW_US, default 0; 1 = '_' classed as letter.
REQ-004 SHALL have parameter STRICT, default 1; 1 = letter after digits restarts identifier, as the legacy letters-then-digits recognizer does; 0 = identifier continues.
REQ-005 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-006 SHALL have port: clk  input  1  rising-edge clock.
REQ-007 SHALL have port: reset  input  1  asynchronous active-high reset.
REQ-008 SHALL have port: char  input  8  ASCII character.
REQ-009 SHALL have port: char_valid  input  1  char sampled this edge when high.
REQ-010 SHALL have port: match  output  1  high while state = ALNUM.
REQ-011 SHALL have port: tok_valid  output  1  one-cycle token-complete pulse.
REQ-012 SHALL have port: tok_type  output  2  0 ALPHA, 1 ALNUM, 2 NUM, 3 BAD; valid with tok_valid.
REQ-013 SHALL have port: tok_len  output  LEN_W  token character count; valid with tok_valid.
REQ-014 SHALL have port: id_count  output  CNT_W  running count of ALPHA+ALNUM tokens.

Function
REQ-015 SHALL classify char: letter = 'A'..'Z', 'a'..'z' (+'_' if ALLOW_US); digit = '0'..'9'; else delimiter.
REQ-016 SHALL implement states IDLE, ALPHA, ALNUM, NUM, BAD; state advances only on edges with char_valid=1; otherwise all state, length and counter hold.
REQ-017 SHALL on letter: IDLE->ALPHA, ALPHA->ALPHA, ALNUM->ALPHA if STRICT=1 else ALNUM, NUM->BAD, BAD->BAD.
REQ-018 SHALL on digit: IDLE->NUM, ALPHA->ALNUM, ALNUM->ALNUM, NUM->NUM, BAD->BAD.
REQ-019 SHALL on delimiter: any state -> IDLE.
REQ-020 SHALL count characters of current token: length register set to 1 on IDLE exit, +1 per further token char, saturating at 2^LEN_W-1; STRICT restart (ALNUM->ALPHA) does not reset length.
REQ-021 SHALL on delimiter sampled in non-IDLE state, assert tok_valid for exactly the next cycle with tok_type = state and tok_len = length at that edge; delimiter in IDLE emits nothing.
REQ-022 SHALL increment id_count (wrapping modulo 2^CNT_W) on the same edge tok_valid rises with tok_type 0 or 1.
REQ-023 SHALL drive match combinationally from registered state only (no char->match path).
REQ-024 SHALL hold tok_type/tok_len stable between pulses.

Reset
REQ-025 SHALL on reset: state=IDLE, length=0, tok_valid=0, tok_type=0, tok_len=0, id_count=0, match=0.
REQ-026 SHALL discard a token in progress when reset asserts mid-token; no tok_valid after release.
REQ-027 SHALL take the first char on the first rising edge after reset deasserts.

Structure
REQ-028 SHALL place state encoding and tok_type codes in shared package id_scan_pkg.
REQ-029 SHALL implement classification in combinational sub-module char_class (outputs is_letter, is_digit; parameter ALLOW_US).

Verification
REQ-030 SHALL test "abc012*" defaults -> match high after '0' through '2'; tok_valid after '*' with type 1, len 6, id_count 1.
REQ-031 SHALL test "a0b1 " STRICT=1 -> match drops after 'b', rises after '1'; token type 1, len 4; STRICT=0 -> match stays high from '0'.
REQ-032 SHALL test "12x;" -> states NUM,NUM,BAD; token type 3, len 3; id_count unchanged.
REQ-033 SHALL test 20-letter identifier + ' ' with LEN_W=4 -> tok_len 15 (saturated), type 0.
REQ-034 SHALL test char_valid=0 for 3 cycles mid "ab" -> no state change; "_a " with ALLOW_US=0 -> '_' is a delimiter, token "a" len 1.
REQ-035 SHALL test reset pulse after "ab", then CNT_W=2 with 5 identifiers -> no token after reset; id_count wraps to 1.

Source files
------------

// File: rtl/id_scan_pkg.sv
// Shared state encoding and token-type codes for the identifier scanner.
package id_scan_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ALPHA = 3'd1;
  localparam logic [2:0] ST_ALNUM = 3'd2;
  localparam logic [2:0] ST_NUM   = 3'd3;
  localparam logic [2:0] ST_BAD   = 3'd4;

  localparam logic [1:0] TOK_ALPHA = 2'd0;
  localparam logic [1:0] TOK_ALNUM = 2'd1;
  localparam logic [1:0] TOK_NUM   = 2'd2;
  localparam logic [1:0] TOK_BAD   = 2'd3;

  // Token type reported when a token in state st is closed by a delimiter.
  function automatic logic [1:0] tok_of_state(input logic [2:0] st);
    logic [1:0] t;
    case (st)
      ST_ALPHA: t = TOK_ALPHA;
      ST_ALNUM: t = TOK_ALNUM;
      ST_NUM:   t = TOK_NUM;
      default:  t = TOK_BAD;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/char_class.sv
// Combinational ASCII classifier: letter, digit, or (neither) delimiter.
module char_class #(
  parameter int ALLOW_US = 0
) (
  input  logic [7:0] char,
  output logic       is_letter,
  output logic       is_digit
);

  logic is_alpha;
  logic is_us;

  always_comb begin
    is_alpha  = ((char >= 8'h41) && (char <= 8'h5a)) || ((char >= 8'h61) && (char <= 8'h7a));
    is_us     = (ALLOW_US != 0) && (char == 8'h5f);
    is_letter = is_alpha || is_us;
    is_digit  = (char >= 8'h30) && (char <= 8'h39);
  end

endmodule

// File: rtl/id_scanner.sv
// Streaming identifier/number tokenizer: tracks the current token class and
// length, pulses tok_valid when a delimiter closes a token, counts identifiers.
module id_scanner
  import id_scan_pkg::*;
#(
  parameter int LEN_W    = 4,
  parameter int CNT_W    = 8,
  parameter int ALLOW_US = 0,
  parameter int STRICT   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char,
  input  logic             char_valid,
  output logic             match,
  output logic             tok_valid,
  output logic [1:0]       tok_type,
  output logic [LEN_W-1:0] tok_len,
  output logic [CNT_W-1:0] id_count
);

  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  logic             is_letter;
  logic             is_digit;
  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             tok_valid_q, tok_valid_d;
  logic [1:0]       tok_type_q, tok_type_d;
  logic [LEN_W-1:0] tok_len_q, tok_len_d;
  logic [CNT_W-1:0] id_count_q, id_count_d;

  char_class #(
    .ALLOW_US (ALLOW_US)
  ) u_char_class (
    .char      (char),
    .is_letter (is_letter),
    .is_digit  (is_digit)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    tok_valid_d = 1'b0;
    tok_type_d  = tok_type_q;
    tok_len_d   = tok_len_q;
    id_count_d  = id_count_q;

    if (char_valid) begin
      if (is_letter) begin
        case (state_q)
          ST_IDLE:  state_d = ST_ALPHA;
          ST_ALPHA: state_d = ST_ALPHA;
          ST_ALNUM: state_d = (STRICT != 0) ? ST_ALPHA : ST_ALNUM;
          default:  state_d = ST_BAD;
        endcase
      end else if (is_digit) begin
        case (state_q)
          ST_IDLE:  state_d = ST_NUM;
          ST_ALPHA: state_d = ST_ALNUM;
          ST_ALNUM: state_d = ST_ALNUM;
          ST_NUM:   state_d = ST_NUM;
          default:  state_d = ST_BAD;
        endcase
      end else begin
        state_d = ST_IDLE;
      end

      if (is_letter || is_digit) begin
        // A strict restart keeps counting: the length spans the whole token.
        if (state_q == ST_IDLE) begin
          len_d = LEN_W'(1);
        end else if (len_q != LEN_MAX) begin
          len_d = len_q + LEN_W'(1);
        end
      end else begin
        len_d = '0;
        if (state_q != ST_IDLE) begin
          tok_valid_d = 1'b1;
          tok_type_d  = tok_of_state(state_q);
          tok_len_d   = len_q;
          if ((tok_type_d == TOK_ALPHA) || (tok_type_d == TOK_ALNUM)) begin
            id_count_d = id_count_q + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      tok_valid_q <= 1'b0;
      tok_type_q  <= 2'd0;
      tok_len_q   <= '0;
      id_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      tok_valid_q <= tok_valid_d;
      tok_type_q  <= tok_type_d;
      tok_len_q   <= tok_len_d;
      id_count_q  <= id_count_d;
    end
  end

  assign match     = (state_q == ST_ALNUM);
  assign tok_valid = tok_valid_q;
  assign tok_type  = tok_type_q;
  assign tok_len   = tok_len_q;
  assign id_count  = id_count_q;

endmodule
